ptw_mem_port: RTL
=================

Name: ptw_mem_port

Overview:
- Memory-side responder for the page-table walker's PTE read interface (walker_req/addr in, walker_data/valid out).
- Arbitrates walker PTE reads and LSU data accesses onto the single data bus (dbus) toward the data cache/memory.
- Returns each PTE as a one-cycle valid pulse.
- Sits between the memory stage (walker + LSU) and the dbus port of the core.

Parameters:
- ADDR_W, 64, address width on all interfaces.
- DATA_W, 64, data width; PTE is one DATA_W word.
- CNT_W, 32, width of the saturating PTE-read counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ptw_req  in  1  walker requests a PTE read; held high while waiting
- ptw_addr  in  ADDR_W  PTE physical address
- ptw_data  out  DATA_W  returned PTE
- ptw_data_valid  out  1  one-cycle pulse: ptw_data valid
- lsu_valid  in  1  LSU request; held until lsu_data_ok
- lsu_addr  in  ADDR_W  LSU address
- lsu_size  in  3  log2 byte size
- lsu_strobe  in  8  byte write strobe (0 = read)
- lsu_wdata  in  DATA_W  store data
- lsu_data_ok  out  1  LSU access complete (one cycle)
- lsu_rdata  out  DATA_W  LSU load data
- dreq_valid  out  1  dbus request valid
- dreq_addr  out  ADDR_W  dbus address
- dreq_size  out  3  dbus size
- dreq_strobe  out  8  dbus strobe
- dreq_data  out  DATA_W  dbus write data
- dresp_addr_ok  in  1  dbus accepted address (informational)
- dresp_data_ok  in  1  dbus transaction complete
- dresp_data  in  DATA_W  dbus read data
- ptw_reads  out  CNT_W  count of PTE reads issued to dbus, saturating

Behaviour:
- Reset values:
  - state IDLE.
  - dreq_valid=0; dreq_addr/size/strobe/data all 0.
  - ptw_data=0, ptw_data_valid=0, lsu_data_ok=0, lsu_rdata=0, ptw_reads=0.
- FSM states: IDLE, PTW_BUSY, PTW_RESP, LSU_BUSY.
- IDLE:
  - ptw_req=1, ptw_addr[2:0]==0: latch the address into the request registers (size=3, strobe=0, data=0); go to PTW_BUSY; increment ptw_reads unless it equals all-ones.
  - ptw_req=1, ptw_addr[2:0]!=0 (misaligned): no bus access; load ptw_data=0 (invalid PTE, V=0); go to PTW_RESP.
  - ptw_req=0 and lsu_valid=1: latch the LSU request; go to LSU_BUSY.
  - Both requesting: walker wins; the LSU waits.
- PTW_BUSY:
  - dreq_valid=1 with the latched fields; ignore changes on ptw_addr.
  - On dresp_data_ok: register dresp_data into ptw_data; go to PTW_RESP.
- PTW_RESP:
  - ptw_data_valid=1 for exactly this cycle; then go to IDLE unconditionally.
  - This mandatory gap cycle lets the walker update its level/address before a new request is sampled.
  - ptw_data holds until the next load.
- LSU_BUSY:
  - dreq_valid=1 with the latched LSU fields.
  - On dresp_data_ok: lsu_data_ok=1 and lsu_rdata=dresp_data in the same cycle (combinational pass-through); go to IDLE.
- Request fields are registered; they change only on the IDLE->BUSY transition. dreq_valid is a decode of state.
- A grant is never pre-empted. A PTW request arriving during LSU_BUSY waits for LSU completion.
- dresp_data_ok in IDLE or PTW_RESP is ignored; no output changes.
- Latency:
  - Walker: dbus latency + 2 cycles (IDLE latch, PTW_RESP pulse).
  - Misaligned PTE: 2 cycles.
- Reset mid-operation:
  - Returns to IDLE immediately; dreq_valid drops the next cycle.
  - No ptw_data_valid or lsu_data_ok pulse for the aborted transaction.
  - A late dresp_data_ok is ignored.
- ptw_reads saturates at 2^CNT_W-1; no wrap.

Decomposition:
- Shared package (pipes):
  - dbus request/response structs (addr, size, strobe, data / addr_ok, data_ok, data).
  - msize_t encoding: MSIZE8=3.
  - PTE_BYTES=8 constant.
  - ptw_port_state_t enum.
- No sub-module needed.
- Optional reusable sat_counter #(W) sub-module for ptw_reads.

Test Plan:
- PTE read, aligned: ptw_req=1, ptw_addr=0x8000_2010, dbus data_ok after 3 cycles with data 0x2000_0C01 -> dreq_addr=0x8000_2010, size=3, strobe=0; ptw_data_valid pulses one cycle with ptw_data=0x2000_0C01; ptw_reads=1.
- Simultaneous requests: ptw_req and lsu_valid (addr 0x8000_0100) asserted in the same cycle -> PTW transaction first; LSU issued only after PTW_RESP and IDLE; lsu_data_ok exactly once.
- Misaligned PTE: ptw_addr=0x8000_2014 -> no dreq_valid; ptw_data_valid pulses 2 cycles later with ptw_data=0; ptw_reads unchanged.
- Three-level walk: three back-to-back PTE requests at new addresses -> three pulses; each dreq_addr matches its request; at least one idle cycle between pulses; ptw_reads=3.
- Reset in PTW_BUSY, then dresp_data_ok=1 one cycle after reset -> no ptw_data_valid pulse; all outputs at reset values; ptw_reads=0.

Source files
------------

// File: rtl/ptw_mem_port_pkg.sv
// Shared dbus types, sizes and walker-port state encoding for ptw_mem_port.
// PTE reads are always one aligned PTE_BYTES word.
package ptw_mem_port_pkg;

  localparam int DBUS_ADDR_W = 64;
  localparam int DBUS_DATA_W = 64;
  localparam int PTR_CNT_W   = 32;
  localparam int PTE_BYTES   = 8;
  localparam int PTE_OFF_W   = $clog2(PTE_BYTES);

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic [DBUS_ADDR_W-1:0] addr;
    msize_t                 size;
    logic [7:0]             strobe;
    logic [DBUS_DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic                   addr_ok;
    logic                   data_ok;
    logic [DBUS_DATA_W-1:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PTW_BUSY = 2'd1,
    PTW_RESP = 2'd2,
    LSU_BUSY = 2'd3
  } ptw_port_state_t;

  function automatic logic pte_aligned(input logic [DBUS_ADDR_W-1:0] addr);
    return addr[PTE_OFF_W-1:0] == '0;
  endfunction

endpackage

// File: rtl/ptw_mem_port_if.sv
// Walker, LSU and dbus signals of the memory-stage port; master is the port
// itself, slave is the surrounding walker/LSU/cache side.
interface ptw_mem_port_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ptw_req;
  logic [ADDR_W-1:0] ptw_addr;
  logic [DATA_W-1:0] ptw_data;
  logic              ptw_data_valid;

  logic              lsu_valid;
  logic [ADDR_W-1:0] lsu_addr;
  logic [2:0]        lsu_size;
  logic [7:0]        lsu_strobe;
  logic [DATA_W-1:0] lsu_wdata;
  logic              lsu_data_ok;
  logic [DATA_W-1:0] lsu_rdata;

  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [2:0]        dreq_size;
  logic [7:0]        dreq_strobe;
  logic [DATA_W-1:0] dreq_data;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;

  modport master (
    input  ptw_req, ptw_addr, lsu_valid, lsu_addr, lsu_size, lsu_strobe, lsu_wdata,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    output ptw_data, ptw_data_valid, lsu_data_ok, lsu_rdata,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
  );

  modport slave (
    output ptw_req, ptw_addr, lsu_valid, lsu_addr, lsu_size, lsu_strobe, lsu_wdata,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    input  ptw_data, ptw_data_valid, lsu_data_ok, lsu_rdata,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
  );
endinterface

// File: rtl/ptw_mem_port_sat_counter.sv
// Saturating up-counter; increments one cycle after inc, holds at all-ones.
// No backpressure: inc is sampled every cycle.
module ptw_mem_port_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ptw_mem_port.sv
// Arbitrates walker PTE reads (priority) and LSU accesses onto one dbus; PTE latency = dbus latency + 2.
// Walker/LSU hold requests until ptw_data_valid / lsu_data_ok; dbus stalls the owner until dresp_data_ok.
module ptw_mem_port
  import ptw_mem_port_pkg::*;
#(
  parameter int ADDR_W = DBUS_ADDR_W,
  parameter int DATA_W = DBUS_DATA_W,
  parameter int CNT_W  = PTR_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  ptw_mem_port_if.master      bus,
  output logic [CNT_W-1:0]    ptw_reads
);

  ptw_port_state_t   state_q, state_d;
  dbus_req_t         req_q, req_d;
  logic [DATA_W-1:0] pte_q, pte_d;
  logic              ptw_issue;
  logic              lsu_done;
  logic              unused_addr_ok;

  // Address acceptance is informational only; completion is keyed on data_ok.
  assign unused_addr_ok = bus.dresp_addr_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      pte_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pte_q   <= pte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    pte_d     = pte_q;
    ptw_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ptw_req) begin
          if (pte_aligned(DBUS_ADDR_W'(bus.ptw_addr))) begin
            req_d     = '{addr: DBUS_ADDR_W'(bus.ptw_addr), size: MSIZE8,
                          strobe: 8'h00, data: '0};
            ptw_issue = 1'b1;
            state_d   = PTW_BUSY;
          end else begin
            // Misaligned PTE: answer with an invalid (V=0) entry, no bus traffic.
            pte_d   = '0;
            state_d = PTW_RESP;
          end
        end else if (bus.lsu_valid) begin
          req_d   = '{addr: DBUS_ADDR_W'(bus.lsu_addr), size: msize_t'(bus.lsu_size),
                      strobe: bus.lsu_strobe, data: DBUS_DATA_W'(bus.lsu_wdata)};
          state_d = LSU_BUSY;
        end
      end
      PTW_BUSY: begin
        if (bus.dresp_data_ok) begin
          pte_d   = DATA_W'(bus.dresp_data);
          state_d = PTW_RESP;
        end
      end
      // Mandatory gap so the walker can advance its level before resampling.
      PTW_RESP: state_d = IDLE;
      LSU_BUSY: begin
        if (bus.dresp_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dreq_valid     = (state_q == PTW_BUSY) || (state_q == LSU_BUSY);
  assign bus.dreq_addr      = ADDR_W'(req_q.addr);
  assign bus.dreq_size      = req_q.size;
  assign bus.dreq_strobe    = req_q.strobe;
  assign bus.dreq_data      = DATA_W'(req_q.data);

  assign bus.ptw_data       = pte_q;
  assign bus.ptw_data_valid = (state_q == PTW_RESP);

  assign lsu_done           = (state_q == LSU_BUSY) && bus.dresp_data_ok && !reset;
  assign bus.lsu_data_ok    = lsu_done;
  assign bus.lsu_rdata      = lsu_done ? DATA_W'(bus.dresp_data) : '0;

  ptw_mem_port_sat_counter #(.W(CNT_W)) u_reads (
    .clk   (clk),
    .reset (reset),
    .inc   (ptw_issue),
    .count (ptw_reads)
  );

endmodule
